// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding/hazard controller.
//  - CSW_* : operand-mux select codes (regfile, MEM-stage result, WB value)
//  - shadow_entry_t : destination-register tag carried down the shadow pipeline
//  - ctrl_state_t   : load-use FSM states
package fwd_hazard_ctrl_pkg;

  localparam int PKG_REG_AW = 5;

  localparam logic [1:0] CSW_REG = 2'b00;
  localparam logic [1:0] CSW_MEM = 2'b01;
  localparam logic [1:0] CSW_WB  = 2'b10;

  // Packed width is PKG_REG_AW + 3.
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [PKG_REG_AW-1:0] rd;
    logic                  load;
  } shadow_entry_t;

  localparam shadow_entry_t ENTRY_BUBBLE = '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_match.sv
// Combinational tag compare of one ID source register against the EX and
// MEM shadow entries.
//  in_src / in_use / in_id_valid : source index, "operand is read", ID valid
//  in_ex / in_mem                : shadow entries of the two older stages
//  out_sel                       : forwarding select for this operand
//  out_ex_load_hit               : source depends on a load still in EX
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [PKG_REG_AW-1:0] in_src,
  input  logic                  in_use,
  input  logic                  in_id_valid,
  input  shadow_entry_t         in_ex,
  input  shadow_entry_t         in_mem,
  output logic [1:0]            out_sel,
  output logic                  out_ex_load_hit
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;

  // r0 is hard-wired zero, so neither a reader nor a writer of r0 forwards.
  assign src_live = in_use & in_id_valid & (in_src != '0);
  assign ex_hit   = src_live & in_ex.valid  & in_ex.wr  & (in_ex.rd  == in_src);
  assign mem_hit  = src_live & in_mem.valid & in_mem.wr & (in_mem.rd == in_src);

  assign out_ex_load_hit = ex_hit & in_ex.load;

  // Youngest producer wins. A load in EX has no data yet, so it falls
  // through to the MEM check (the stall logic handles that case).
  always_comb begin
    out_sel = CSW_REG;
    if (ex_hit && !in_ex.load) begin
      out_sel = CSW_MEM;
    end else if (mem_hit) begin
      out_sel = CSW_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the EX-stage operand muxes.
// Tracks destination tags of the instructions in EX and MEM, produces
// registered operand selects, inserts one bubble per load-use and honours
// flush (taken branch) and freeze (memory not ready).
//  in_clk, in_rst_n        : clock, synchronous active-low reset
//  in_mem_stall, in_flush  : freeze whole controller / kill ID instruction
//  in_id_*                 : decoded ID-stage instruction
//  out_CSW_A, out_CSW_B    : registered operand selects
//  out_stall               : hold PC and IF/ID (combinational)
//  out_bubble              : EX holds a bubble (registered)
//  out_stall_cnt           : saturating count of load-use stalls
// A producer in MEM is selected with CSW_WB because by the time the ID
// instruction reaches EX that producer has moved on to WB; the tag that
// leaves MEM is therefore not needed for any compare and is not kept.
// REG_AW must match PKG_REG_AW (the shadow tag width).
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = PKG_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_mem_stall,
  input  logic              in_flush,
  input  logic              in_id_valid,
  input  logic [REG_AW-1:0] in_id_rs,
  input  logic [REG_AW-1:0] in_id_rt,
  input  logic              in_id_use_rs,
  input  logic              in_id_use_rt,
  input  logic              in_id_wr,
  input  logic [REG_AW-1:0] in_id_rd,
  input  logic              in_id_load,
  output logic [1:0]        out_CSW_A,
  output logic [1:0]        out_CSW_B,
  output logic              out_stall,
  output logic              out_bubble,
  output logic [CNT_W-1:0]  out_stall_cnt
);

  shadow_entry_t     ex_q, ex_d;
  shadow_entry_t     mem_q, mem_d;
  ctrl_state_t       state_q, state_d;
  logic [1:0]        csw_a_q, csw_a_d;
  logic [1:0]        csw_b_q, csw_b_d;
  logic              bubble_q, bubble_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0]        sel_a, sel_b;
  logic              lu_a, lu_b;
  logic              load_use;
  logic              stall;
  logic              kill;
  shadow_entry_t     id_entry;

  fwd_match u_match_a (
    .in_src          (in_id_rs),
    .in_use          (in_id_use_rs),
    .in_id_valid     (in_id_valid),
    .in_ex           (ex_q),
    .in_mem          (mem_q),
    .out_sel         (sel_a),
    .out_ex_load_hit (lu_a)
  );

  fwd_match u_match_b (
    .in_src          (in_id_rt),
    .in_use          (in_id_use_rt),
    .in_id_valid     (in_id_valid),
    .in_ex           (ex_q),
    .in_mem          (mem_q),
    .out_sel         (sel_b),
    .out_ex_load_hit (lu_b)
  );

  // STALL masks the load-use test on the retry cycle; by then the load has
  // moved to MEM and the retried instruction simply forwards from WB.
  assign load_use = (lu_a | lu_b) & (state_q == ST_RUN);
  // Flush wins over a load-use: the dependant is being killed anyway.
  assign stall    = in_rst_n & load_use & ~in_flush & ~in_mem_stall;
  assign kill     = stall | in_flush | ~in_id_valid;

  assign id_entry = '{valid: 1'b1, wr: in_id_wr, rd: in_id_rd, load: in_id_load};

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    state_d     = state_q;
    csw_a_d     = csw_a_q;
    csw_b_d     = csw_b_q;
    bubble_d    = bubble_q;
    stall_cnt_d = stall_cnt_q;
    if (!in_mem_stall) begin
      mem_d    = ex_q;
      ex_d     = kill ? ENTRY_BUBBLE : id_entry;
      csw_a_d  = kill ? CSW_REG : sel_a;
      csw_b_d  = kill ? CSW_REG : sel_b;
      bubble_d = stall | in_flush;
      state_d  = stall ? ST_STALL : ST_RUN;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      ex_q        <= ENTRY_BUBBLE;
      mem_q       <= ENTRY_BUBBLE;
      state_q     <= ST_RUN;
      csw_a_q     <= CSW_REG;
      csw_b_q     <= CSW_REG;
      bubble_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      state_q     <= state_d;
      csw_a_q     <= csw_a_d;
      csw_b_q     <= csw_b_d;
      bubble_q    <= bubble_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_CSW_A     = csw_a_q;
  assign out_CSW_B     = csw_b_q;
  assign out_stall     = stall;
  assign out_bubble    = bubble_q;
  assign out_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, a hand-written
// freeze/reset-mid-stall sequence, then random stimulus against a
// history-based reference model.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_stall, flush, id_valid;
  logic [4:0]  rs, rt, rd;
  logic        use_rs, use_rt, id_wr, id_load;
  logic [1:0]  csw_a, csw_b;
  logic        stall, bubble;
  logic [15:0] cnt;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_mem_stall  (mem_stall),
    .in_flush      (flush),
    .in_id_valid   (id_valid),
    .in_id_rs      (rs),
    .in_id_rt      (rt),
    .in_id_use_rs  (use_rs),
    .in_id_use_rt  (use_rt),
    .in_id_wr      (id_wr),
    .in_id_rd      (rd),
    .in_id_load    (id_load),
    .out_CSW_A     (csw_a),
    .out_CSW_B     (csw_b),
    .out_stall     (stall),
    .out_bubble    (bubble),
    .out_stall_cnt (cnt)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- vector records ----------------
  typedef struct {
    logic r, ms, fl, v;
    logic [4:0] rs; logic urs;
    logic [4:0] rt; logic urt;
    logic wr; logic [4:0] rd; logic ld;
    logic e_stall; logic [1:0] e_a, e_b; logic e_bub; logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit ms, bit fl, bit v, int s_rs, bit urs,
                              int s_rt, bit urt, bit wr, int s_rd, bit ld,
                              bit es, int ea, int eb, bit ebub, int ec);
    vec_t x;
    x.r = r; x.ms = ms; x.fl = fl; x.v = v;
    x.rs = 5'(s_rs); x.urs = urs; x.rt = 5'(s_rt); x.urt = urt;
    x.wr = wr; x.rd = 5'(s_rd); x.ld = ld;
    x.e_stall = es; x.e_a = 2'(ea); x.e_b = 2'(eb); x.e_bub = ebub; x.e_cnt = 16'(ec);
    return x;
  endfunction

  // ---------------- reference model ----------------
  // hist[0] is the most recently issued instruction (now in EX), hist[1]
  // the one before it (now in MEM); killed slots are recorded as not valid.
  typedef struct { bit v; bit wr; bit ld; int rd; } tag_t;
  tag_t hist[2];
  bit   after_lu;        // previous advance was a load-use bubble
  int   m_a, m_b, m_bub, m_cnt;

  function automatic bit hits(tag_t t, int s, bit u);
    return t.v && t.wr && (t.rd == s) && (s != 0) && u && id_valid;
  endfunction

  function automatic int exp_sel(int s, bit u);
    for (int age = 0; age < 2; age++) begin
      if (hits(hist[age], s, u)) begin
        if (age == 0 && hist[0].ld) continue;   // load data not ready yet
        return (age == 0) ? 1 : 2;
      end
    end
    return 0;
  endfunction

  function automatic bit model_stall();
    bit dep;
    dep = hits(hist[0], int'(rs), use_rs) || hits(hist[0], int'(rt), use_rt);
    return rst_n && dep && hist[0].ld && !after_lu && !flush && !mem_stall;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) hist[i] = '{0, 0, 0, 0};
    after_lu = 0; m_a = 0; m_b = 0; m_bub = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit st, kill;
    int sa, sb;
    tag_t nt;
    if (!rst_n) begin
      model_reset();
    end else if (!mem_stall) begin
      st   = model_stall();
      sa   = exp_sel(int'(rs), use_rs);
      sb   = exp_sel(int'(rt), use_rt);
      kill = st || flush || !id_valid;
      nt   = kill ? '{0, 0, 0, 0} : '{1, id_wr, id_load, int'(rd)};
      hist[1] = hist[0];
      hist[0] = nt;
      m_a   = kill ? 0 : sa;
      m_b   = kill ? 0 : sb;
      m_bub = (st || flush) ? 1 : 0;
      if (st && m_cnt < 65535) m_cnt++;
      after_lu = st;
    end
  endtask

  // ---------------- one cycle ----------------
  task automatic drive(vec_t x);
    rst_n = x.r; mem_stall = x.ms; flush = x.fl; id_valid = x.v;
    rs = x.rs; use_rs = x.urs; rt = x.rt; use_rt = x.urt;
    id_wr = x.wr; rd = x.rd; id_load = x.ld;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(string tag, int idx, bit use_tab, vec_t x);
    int es, ea, eb, ebub, ec;
    drive(x);
    @(negedge clk);
    es = use_tab ? int'(x.e_stall) : int'(model_stall());
    chk($sformatf("%s[%0d].stall", tag, idx), int'(stall), es);
    model_edge();
    @(posedge clk);
    #1;
    if (use_tab) begin
      ea = x.e_a; eb = x.e_b; ebub = x.e_bub; ec = x.e_cnt;
    end else begin
      ea = m_a; eb = m_b; ebub = m_bub; ec = m_cnt;
    end
    chk($sformatf("%s[%0d].csw_a", tag, idx), int'(csw_a), ea);
    chk($sformatf("%s[%0d].csw_b", tag, idx), int'(csw_b), eb);
    chk($sformatf("%s[%0d].bubble", tag, idx), int'(bubble), ebub);
    chk($sformatf("%s[%0d].cnt", tag, idx), int'(cnt), ec);
    $display("%s[%0d] rst_n=%0b ms=%0b fl=%0b v=%0b rs=%0d rt=%0d rd=%0d ld=%0b -> stall=%0d A=%0d B=%0d bub=%0d cnt=%0d",
             tag, idx, x.r, x.ms, x.fl, x.v, x.rs, x.rt, x.rd, x.ld,
             es, csw_a, csw_b, bubble, cnt);
  endtask

  vec_t tab[$];
  vec_t seq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    model_reset();
    rst_n = 0; mem_stall = 0; flush = 0; id_valid = 0;
    rs = 0; rt = 0; rd = 0; use_rs = 0; use_rt = 0; id_wr = 0; id_load = 0;

    //          r ms fl v  rs u  rt u  wr rd ld | st A  B  bub cnt
    tab.push_back(mk(0,0,0,0, 0,0, 0,0, 0, 0,0,  0, 0, 0, 0, 0)); // reset state
    tab.push_back(mk(1,0,0,1, 1,1, 2,1, 1, 3,0,  0, 0, 0, 0, 0)); // add r3
    tab.push_back(mk(1,0,0,1, 3,1, 3,1, 1, 4,0,  0, 1, 1, 0, 0)); // add r4,r3,r3
    tab.push_back(mk(1,0,0,1, 0,0, 0,0, 0, 0,0,  0, 0, 0, 0, 0)); // nop
    tab.push_back(mk(1,0,0,1, 0,0, 0,0, 0, 0,0,  0, 0, 0, 0, 0)); // nop
    tab.push_back(mk(1,0,0,1, 1,1, 2,1, 1, 3,0,  0, 0, 0, 0, 0)); // add r3
    tab.push_back(mk(1,0,0,1, 0,0, 0,0, 0, 0,0,  0, 0, 0, 0, 0)); // nop
    tab.push_back(mk(1,0,0,1, 7,1, 3,1, 0, 0,0,  0, 0, 2, 0, 0)); // sw r3 -> B=WB
    tab.push_back(mk(1,0,0,1, 1,1, 0,0, 1, 5,1,  0, 0, 0, 0, 0)); // lw r5
    tab.push_back(mk(1,0,0,1, 5,1, 0,1, 1, 6,0,  1, 0, 0, 1, 1)); // add r6,r5,r0 stall
    tab.push_back(mk(1,0,0,1, 5,1, 0,1, 1, 6,0,  0, 2, 0, 0, 1)); // retry -> A=WB
    tab.push_back(mk(1,0,0,1, 1,1, 0,0, 1, 5,1,  0, 0, 0, 0, 1)); // lw r5
    tab.push_back(mk(1,0,1,1, 5,1, 5,1, 1, 7,0,  0, 0, 0, 1, 1)); // dependant + flush
    tab.push_back(mk(1,0,0,1, 0,0, 0,0, 0, 0,0,  0, 0, 0, 0, 1)); // nop
    tab.push_back(mk(1,0,0,1, 1,1, 2,1, 1, 0,0,  0, 0, 0, 0, 1)); // write r0
    tab.push_back(mk(1,0,0,1, 0,1, 0,1, 1, 8,0,  0, 0, 0, 0, 1)); // read r0
    tab.push_back(mk(1,0,0,1, 0,1, 0,0, 1, 0,1,  0, 0, 0, 0, 1)); // lw r0
    tab.push_back(mk(1,0,0,1, 0,1, 0,1, 1, 9,0,  0, 0, 0, 0, 1)); // read r0, no stall
    tab.push_back(mk(1,0,0,1, 1,1, 2,1, 1, 3,0,  0, 0, 0, 0, 1)); // add r3
    tab.push_back(mk(1,0,0,1, 1,1, 2,1, 1, 3,0,  0, 0, 0, 0, 1)); // add r3 again
    tab.push_back(mk(1,0,0,1, 3,1, 3,0, 1,10,0,  0, 1, 0, 0, 1)); // youngest wins, B unused

    // Freeze mid-load-use, then reset while in STALL.
    seq.push_back(mk(1,0,0,1, 1,1, 2,1, 1, 3,0,  0, 0, 0, 0, 1)); // add r3
    seq.push_back(mk(1,0,0,1, 3,1, 0,0, 1, 5,1,  0, 1, 0, 0, 1)); // lw r5 (base r3)
    seq.push_back(mk(1,1,1,1, 5,1, 5,1, 1, 6,0,  0, 1, 0, 0, 1)); // freeze, flush ignored
    seq.push_back(mk(1,1,0,1, 5,1, 5,1, 1, 6,0,  0, 1, 0, 0, 1)); // freeze
    seq.push_back(mk(1,1,0,1, 5,1, 5,1, 1, 6,0,  0, 1, 0, 0, 1)); // freeze
    seq.push_back(mk(1,0,0,1, 5,1, 5,1, 1, 6,0,  1, 0, 0, 1, 2)); // load-use stall
    seq.push_back(mk(1,1,0,1, 5,1, 5,1, 1, 6,0,  0, 0, 0, 1, 2)); // freeze in STALL
    seq.push_back(mk(0,0,0,1, 5,1, 5,1, 1, 6,0,  0, 0, 0, 0, 0)); // reset mid-STALL
    seq.push_back(mk(1,0,0,1, 5,1, 5,1, 1, 6,0,  0, 0, 0, 0, 0)); // retry after reset

    @(posedge clk);
    #1;
    for (int i = 0; i < tab.size(); i++) cycle("tab", i, 1'b1, tab[i]);
    for (int i = 0; i < seq.size(); i++) cycle("seq", i, 1'b1, seq[i]);

    for (int i = 0; i < 400; i++) begin
      rv.r   = ($urandom_range(0, 63) != 0);
      rv.ms  = ($urandom_range(0, 5) == 0);
      rv.fl  = ($urandom_range(0, 7) == 0);
      rv.v   = ($urandom_range(0, 7) != 0);
      rv.rs  = 5'($urandom_range(0, 7));
      rv.rt  = 5'($urandom_range(0, 7));
      rv.rd  = 5'($urandom_range(0, 7));
      rv.urs = 1'($urandom_range(0, 1));
      rv.urt = 1'($urandom_range(0, 1));
      rv.wr  = ($urandom_range(0, 3) != 0);
      rv.ld  = ($urandom_range(0, 2) == 0);
      rv.e_stall = 0; rv.e_a = 0; rv.e_b = 0; rv.e_bub = 0; rv.e_cnt = 0;
      cycle("rnd", i, 1'b0, rv);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
